// File: rtl/linebuf_pkg.sv
// Shared definitions for the 3-row line buffer: controller state,
// row counter width and the line-length clamp helper.
package linebuf_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam int ROW_W = 16;

   // A zero or oversized line length cannot be stored; fall back to the full RAM depth.
   function automatic int clamp_len(input int len, input int max_w);
      return ((len == 0) || (len > max_w)) ? max_w : len;
   endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port line RAM, read-before-write: rd shows the word at addr as it
// was before any write on the coming edge, so the caller can capture the old
// contents while replacing them in the same cycle.
module line_ram #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rd
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rd = mem[addr];

   // Write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/line_buffer_3row.sv
// Raster-to-column feeder for the 3x3 kernel. Two line RAMs hold the previous
// two lines; every accepted pixel produces a registered (top, mid, bot) column.
// Optional build macro LINEBUF_ZERO_PAD_EN: emit output from row 0 with a zero
// top border instead of suppressing the first two rows.
module line_buffer_3row
   import linebuf_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int MAX_WIDTH   = 640,
   parameter int COL_W       = $clog2(MAX_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [COL_W-1:0]       line_len,
   input  logic [PIXEL_WIDTH-1:0] pix_in,
   input  logic                   pix_valid,
   input  logic                   sof,
   output logic [PIXEL_WIDTH-1:0] pix_top,
   output logic [PIXEL_WIDTH-1:0] pix_mid,
   output logic [PIXEL_WIDTH-1:0] pix_bot,
   output logic                   out_valid,
   output logic                   out_sol,
   output logic                   out_eol,
   output logic [15:0]            out_row,
   output logic                   len_err
);

   localparam logic [ROW_W-1:0] ROW_MAX = '1;

   state_t                   state;
   logic [COL_W-1:0]         col;
   logic [COL_W:0]           len;
   logic [ROW_W-1:0]         row;

   logic                     accept;
   logic                     len_bad;
   logic                     last_col;
   logic                     show;
   logic                     zero_top;
   logic                     zero_mid;
   logic [COL_W-1:0]         col_eff;
   logic [COL_W:0]           len_eff;
   logic [ROW_W-1:0]         row_eff;
   logic [PIXEL_WIDTH-1:0]   ram1_rd;
   logic [PIXEL_WIDTH-1:0]   ram2_rd;

   // Acceptance and the effective (col, row, len) of this pixel; an sof pixel is (0,0) with the new length.
   always_comb begin
      accept   = pix_valid && (sof || (state == ACTIVE));
      col_eff  = sof ? '0 : col;
      row_eff  = sof ? '0 : row;
      len_bad  = (line_len == '0) || (int'(line_len) > MAX_WIDTH);
      len_eff  = sof ? (COL_W+1)'(clamp_len(int'(line_len), MAX_WIDTH)) : len;
      last_col = ({1'b0, col_eff} == (len_eff - 1'b1));
`ifdef LINEBUF_ZERO_PAD_EN
      show     = 1'b1;
      zero_top = (row_eff < ROW_W'(2));
      zero_mid = (row_eff == '0);
`else
      // The first two rows only prime the RAMs, so their stale words never reach the output.
      show     = (row_eff >= ROW_W'(2));
      zero_top = 1'b0;
      zero_mid = 1'b0;
`endif
   end

   // ram1 keeps the previous line, ram2 the line before it; ram1's old word shifts into ram2.
   line_ram #(.DEPTH(MAX_WIDTH), .WIDTH(PIXEL_WIDTH), .AW(COL_W)) ram1 (
      .clk   (clk),
      .we    (accept),
      .addr  (col_eff),
      .wdata (pix_in),
      .rd    (ram1_rd)
   );

   line_ram #(.DEPTH(MAX_WIDTH), .WIDTH(PIXEL_WIDTH), .AW(COL_W)) ram2 (
      .clk   (clk),
      .we    (accept),
      .addr  (col_eff),
      .wdata (ram1_rd),
      .rd    (ram2_rd)
   );

   // Controller, counters and registered column outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         len       <= (COL_W+1)'(MAX_WIDTH);
         pix_top   <= '0;
         pix_mid   <= '0;
         pix_bot   <= '0;
         out_valid <= 1'b0;
         out_sol   <= 1'b0;
         out_eol   <= 1'b0;
         out_row   <= '0;
         len_err   <= 1'b0;
      end else begin
         out_valid <= accept && show;
         out_sol   <= accept && show && (col_eff == '0);
         out_eol   <= accept && show && last_col;
         if (accept) begin
            if (sof) begin
               state   <= ACTIVE;
               len     <= len_eff;
               len_err <= len_err | len_bad;
            end
            if (last_col) begin
               col <= '0;
               row <= (row_eff == ROW_MAX) ? ROW_MAX : row_eff + 1'b1;
            end else begin
               col <= col_eff + 1'b1;
               row <= row_eff;
            end
            pix_bot <= pix_in;
            pix_mid <= zero_mid ? '0 : ram1_rd;
            pix_top <= zero_top ? '0 : ram2_rd;
            out_row <= row_eff;
         end
      end
   end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Self-checking bench for line_buffer_3row against a frame-image reference model.
module tb_line_buffer_3row;

`ifdef LINEBUF_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   localparam int MAXW = 640;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] line_len = '0;
   logic [7:0] pix_in = '0;
   logic       pix_valid = 1'b0;
   logic       sof = 1'b0;
   logic [7:0] pix_top, pix_mid, pix_bot;
   logic       out_valid, out_sol, out_eol, len_err;
   logic [15:0] out_row;

   line_buffer_3row dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .line_len  (line_len),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .sof       (sof),
      .pix_top   (pix_top),
      .pix_mid   (pix_mid),
      .pix_bot   (pix_bot),
      .out_valid (out_valid),
      .out_sol   (out_sol),
      .out_eol   (out_eol),
      .out_row   (out_row),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int n_valid  = 0;

   // Reference model: image rows kept by row number (mod 4), plus position state.
   logic [7:0] pic [4][MAXW];
   bit m_active = 0;
   bit m_err    = 0;
   int m_row = 0, m_col = 0, m_len = MAXW;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pix_valid = 1'b0;
      sof = 1'b0;
      @(posedge clk); #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_sol", out_sol, 0);
      chk("rst_eol", out_eol, 0);
      chk("rst_top", pix_top, 0);
      chk("rst_mid", pix_mid, 0);
      chk("rst_bot", pix_bot, 0);
      chk("rst_row", out_row, 0);
      chk("rst_err", len_err, 0);
      rst_n = 1'b1;
      m_active = 0; m_err = 0; m_row = 0; m_col = 0;
   endtask

   task automatic step(input bit v, input bit s, input int len, input logic [7:0] p);
      bit acc, ev;
      logic [7:0] et, em;
      pix_valid = v; sof = s; line_len = len[9:0]; pix_in = p;
      @(posedge clk); #1;
      acc = v && (s || m_active);
      if (acc && s) begin
         m_len = (len == 0 || len > MAXW) ? MAXW : len;
         if (len == 0 || len > MAXW) m_err = 1;
         m_row = 0; m_col = 0; m_active = 1;
      end
      ev = acc && (m_row >= 2 || PAD);
      chk("valid", out_valid, ev);
      if (out_valid) n_valid++;
      if (ev) begin
         et = (m_row >= 2) ? pic[(m_row - 2) % 4][m_col] : 8'd0;
         em = (m_row >= 1) ? pic[(m_row - 1) % 4][m_col] : 8'd0;
         chk("top", pix_top, et);
         chk("mid", pix_mid, em);
         chk("bot", pix_bot, p);
         chk("sol", out_sol, m_col == 0);
         chk("eol", out_eol, m_col == m_len - 1);
         chk("row", out_row, m_row);
      end
      chk("len_err", len_err, m_err);
      if (acc) begin
         pic[m_row % 4][m_col] = p;
         if (m_col == m_len - 1) begin
            m_col = 0;
            if (m_row < 65535) m_row++;
         end else begin
            m_col++;
         end
      end
   endtask

   // Frame of len x rows, pixel = base + 10*row + col, optional 1,0,0,1 gapping.
   task automatic frame(input int len, input int rows, input int base, input bit gap);
      int k = 0;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < len; c++) begin
            step(1, (r == 0 && c == 0), len, 8'(base + 10 * r + c));
            if (r == 2 && c == 1 && base == 0) begin
               chk("ex_top", pix_top, 1);
               chk("ex_mid", pix_mid, 11);
               chk("ex_bot", pix_bot, 21);
               chk("ex_row", out_row, 2);
            end
            if (gap && (k % 2 == 0)) begin
               step(0, 0, len, 8'hAA);
               step(0, 0, len, 8'h55);
            end
            k++;
         end
      end
   endtask

   initial begin
      // reset and idle behaviour
      do_reset();
      for (int i = 0; i < 5; i++) step(0, 0, 4, 8'h00);
      chk("idle_top", pix_top, 0);
      chk("idle_mid", pix_mid, 0);
      chk("idle_bot", pix_bot, 0);
      chk("idle_row", out_row, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 4, 8'(i + 1));

      // basic 4x3 frame
      n_valid = 0;
      frame(4, 3, 0, 0);
      step(0, 0, 4, 0);
      chk("frame_cols", n_valid, PAD ? 12 : 4);

      // gapped copy of the same frame
      n_valid = 0;
      frame(4, 3, 0, 1);
      step(0, 0, 4, 0);
      chk("gap_cols", n_valid, PAD ? 12 : 4);

      // mid-frame sof at row 3 col 2
      frame(4, 3, 0, 0);
      step(1, 0, 4, 8'd30);
      step(1, 0, 4, 8'd31);
      step(1, 1, 4, 8'd100);
      chk("restart_row", out_row, 0);
      for (int i = 1; i < 16; i++) step(1, 0, 4, 8'(100 + i));

      // zero length clamps to full width
      step(1, 1, 0, 8'($urandom));
      chk("len0_err", len_err, 1);
      for (int i = 1; i < 3 * MAXW; i++) step(1, 0, 0, 8'($urandom));

      // minimum width
      do_reset();
      frame(1, 5, 50, 0);

      // reset in the middle of a line; next pixel without sof is ignored
      frame(5, 3, 0, 0);
      step(1, 1, 5, 8'd9);
      step(1, 0, 5, 8'd8);
      do_reset();
      step(1, 0, 5, 8'd7);
      step(1, 0, 5, 8'd6);

      // randomized frames with random gaps and occasional early restart
      for (int f = 0; f < 25; f++) begin
         int len  = $urandom_range(1, 24);
         int rows = $urandom_range(2, 6);
         int stop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len * rows) : len * rows;
         for (int k = 0; k < stop; k++) begin
            step(1, (k == 0), len, 8'($urandom));
            while ($urandom_range(0, 3) == 0) step(0, $urandom_range(0, 1), len, 8'($urandom));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

endmodule
